// File: rtl/fir_par2ser.sv
// ---------------------------------------------------------------------------
// fir_par2ser
//
// Purpose:
//   Serialises blocks of L samples from a parallel (polyphase) FIR into a
//   stream with one 32-bit sample per transfer. Whole blocks wait in a
//   DEPTH-entry circular FIFO. The element of the head block that is on
//   the output is chosen by a sample index.
//   There is no input backpressure. A block that arrives while the FIFO is
//   full, and that is not freed by a pop in the same cycle, is dropped. A
//   drop sets a sticky overflow flag.
//
// Build option:
//   FIR_P2S_DROP_CNT_EN  When defined, adds a saturating 16-bit drop_cnt
//                        output that counts dropped blocks.
//
// Parameters:
//   L      samples per input block (2 or 3)
//   DEPTH  FIFO depth in blocks (power of two, >= 2)
//
// Ports:
//   clk        sole clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   in_blk is presented this cycle
//   in_blk     L x 32 block, element 0 = oldest sample
//   out_valid  out_data holds a valid sample
//   out_ready  downstream accepts out_data
//   out_data   serial output sample
//   out_last   out_data is element L-1 of its block
//   overflow   sticky flag, a block was dropped
//   clr_ovf    synchronous clear of overflow (and drop_cnt)
//   drop_cnt   dropped-block counter (only with FIR_P2S_DROP_CNT_EN)
// ---------------------------------------------------------------------------
module fir_par2ser #(
    parameter int L     = 3,
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [L-1:0][31:0] in_blk,
    output logic               out_valid,
    input  logic               out_ready,
    output logic signed [31:0] out_data,
    output logic               out_last,
    output logic               overflow,
    input  logic               clr_ovf
`ifdef FIR_P2S_DROP_CNT_EN
    ,
    output logic [15:0]        drop_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int IW = $clog2(L);
    localparam logic [AW:0]   FULL     = (AW+1)'(DEPTH);
    localparam logic [IW-1:0] LAST_IDX = IW'(L - 1);

    typedef logic [L-1:0][31:0] blk_t;

    blk_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [IW-1:0] idx;

    logic transfer;
    logic pop_now;
    logic push;
    logic drop;

    // A pop at the end of a block frees one slot in the same cycle. A
    // block arriving then is therefore accepted, even with a full FIFO.
    always_comb begin
        out_valid = (count != '0);
        out_data  = mem[rd_ptr][idx];
        out_last  = out_valid && (idx == LAST_IDX);
        transfer  = out_valid && out_ready;
        pop_now   = transfer && (idx == LAST_IDX);
        push      = in_valid && ((count != FULL) || pop_now);
        drop      = in_valid && (count == FULL) && !pop_now;
    end

    // Block storage is not reset. The count alone decides which entries
    // are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_blk;
        end
    end

    // The pointers wrap naturally, because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            idx      <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_now) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop_now) begin
                count <= count + (AW+1)'(1);
            end else if (pop_now && !push) begin
                count <= count - (AW+1)'(1);
            end
            if (transfer) begin
                idx <= (idx == LAST_IDX) ? '0 : idx + IW'(1);
            end
            // A drop in the same cycle as a clear leaves the flag set.
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

`ifdef FIR_P2S_DROP_CNT_EN
    // This counter saturates. A drop outranks a clear in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (drop) begin
            if (drop_cnt != 16'hFFFF) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end else if (clr_ovf) begin
            drop_cnt <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_fir_par2ser.sv
// ---------------------------------------------------------------------------
// tb_fir_par2ser
//
// Purpose:
//   Self-checking bench for fir_par2ser. It uses directed vectors whose
//   expected values are written out by hand. Instance u_a uses L=3 and
//   DEPTH=4. Instance u_b uses L=2 and DEPTH=4, and carries the long
//   streaming run.
//   Inputs change 1 ns after the rising edge. Outputs are sampled in the
//   same window, well away from the next edge.
//   The drop_cnt checks are active when FIR_P2S_DROP_CNT_EN is defined.
// ---------------------------------------------------------------------------
module tb_fir_par2ser;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    logic              a_in_valid;
    logic [2:0][31:0]  a_blk;
    logic              a_out_valid;
    logic              a_out_ready;
    logic signed [31:0] a_out_data;
    logic              a_out_last;
    logic              a_overflow;
    logic              a_clr_ovf;

    logic              b_in_valid;
    logic [1:0][31:0]  b_blk;
    logic              b_out_valid;
    logic              b_out_ready;
    logic signed [31:0] b_out_data;
    logic              b_out_last;
    logic              b_overflow;
    logic              b_clr_ovf;

`ifdef FIR_P2S_DROP_CNT_EN
    logic [15:0] a_drop_cnt;
    logic [15:0] b_drop_cnt;
`endif

    fir_par2ser #(.L(3), .DEPTH(4)) u_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (a_in_valid),
        .in_blk    (a_blk),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_data  (a_out_data),
        .out_last  (a_out_last),
        .overflow  (a_overflow),
        .clr_ovf   (a_clr_ovf)
`ifdef FIR_P2S_DROP_CNT_EN
        ,
        .drop_cnt  (a_drop_cnt)
`endif
    );

    fir_par2ser #(.L(2), .DEPTH(4)) u_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (b_in_valid),
        .in_blk    (b_blk),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_data  (b_out_data),
        .out_last  (b_out_last),
        .overflow  (b_overflow),
        .clr_ovf   (b_clr_ovf)
`ifdef FIR_P2S_DROP_CNT_EN
        ,
        .drop_cnt  (b_drop_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Moves to 1 ns after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Element e of numbered test block k. The middle element is negative.
    function automatic int blk_val(input int k, input int e);
        int v;
        v = k * 100 + e;
        return (e == 1) ? -v : v;
    endfunction

    task automatic load_a(input int k);
        for (int e = 0; e < 3; e++) begin
            a_blk[e] = blk_val(k, e);
        end
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        a_in_valid  = 1'b0;
        a_blk       = '0;
        a_out_ready = 1'b0;
        a_clr_ovf   = 1'b0;
        b_in_valid  = 1'b0;
        b_blk       = '0;
        b_out_ready = 1'b0;
        b_clr_ovf   = 1'b0;
        #2;
        checks++;
        if (a_out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_out_valid got=%b exp=0", a_out_valid);
        end
        checks++;
        if (a_out_last !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_out_last got=%b exp=0", a_out_last);
        end
        checks++;
        if (a_overflow !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_overflow got=%b exp=0", a_overflow);
        end
`ifdef FIR_P2S_DROP_CNT_EN
        checks++;
        if (a_drop_cnt !== 16'd0) begin
            errors++;
            $display("[TB] FAIL reset_drop_cnt got=%0d exp=0", a_drop_cnt);
        end
`endif
        #20;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_block();
        int exp_d[3];
        exp_d = '{10, -20, 30};
        a_out_ready = 1'b1;
        a_blk[0] = 32'd10;
        a_blk[1] = -32'sd20;
        a_blk[2] = 32'd30;
        a_in_valid = 1'b1;
        tick();
        a_in_valid = 1'b0;
        for (int e = 0; e < 3; e++) begin
            checks++;
            if (a_out_valid !== 1'b1 || a_out_data !== exp_d[e] || a_out_last !== (e == 2)) begin
                errors++;
                $display("[TB] FAIL single_elem%0d got v=%b d=%0d l=%b exp v=1 d=%0d l=%b",
                         e, a_out_valid, a_out_data, a_out_last, exp_d[e], (e == 2));
            end
            tick();
        end
        checks++;
        if (a_out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_empty got=%b exp=0", a_out_valid);
        end
    endtask

    task automatic test_backpressure();
        a_out_ready = 1'b1;
        a_blk[0] = 32'd10;
        a_blk[1] = -32'sd20;
        a_blk[2] = 32'd30;
        a_in_valid = 1'b1;
        tick();
        a_in_valid = 1'b0;
        checks++;
        if (a_out_data !== 32'sd10) begin
            errors++;
            $display("[TB] FAIL bp_first got=%0d exp=10", a_out_data);
        end
        tick();
        a_out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (a_out_valid !== 1'b1 || a_out_data !== -32'sd20 || a_out_last !== 1'b0) begin
                errors++;
                $display("[TB] FAIL bp_hold%0d got v=%b d=%0d l=%b exp v=1 d=-20 l=0",
                         c, a_out_valid, a_out_data, a_out_last);
            end
            tick();
        end
        checks++;
        if (a_out_data !== -32'sd20) begin
            errors++;
            $display("[TB] FAIL bp_hold_end got=%0d exp=-20", a_out_data);
        end
        a_out_ready = 1'b1;
        tick();
        checks++;
        if (a_out_valid !== 1'b1 || a_out_data !== 32'sd30 || a_out_last !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bp_resume got v=%b d=%0d l=%b exp v=1 d=30 l=1",
                     a_out_valid, a_out_data, a_out_last);
        end
        tick();
        checks++;
        if (a_out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_empty got=%b exp=0", a_out_valid);
        end
    endtask

    // Fills the FIFO, then pushes a fifth block, which is dropped. It then
    // checks clr_ovf precedence and a push with a pop at full. Finally it
    // drains the FIFO to show which blocks were kept.
    task automatic test_full_fifo();
        int order[4];
        order = '{2, 3, 4, 7};
        a_out_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            load_a(k);
            a_in_valid = 1'b1;
            tick();
        end
        a_in_valid = 1'b0;
        checks++;
        if (a_overflow !== 1'b1) begin
            errors++;
            $display("[TB] FAIL full_overflow got=%b exp=1", a_overflow);
        end
        checks++;
        if (a_out_valid !== 1'b1 || a_out_data !== blk_val(1, 0)) begin
            errors++;
            $display("[TB] FAIL full_head got v=%b d=%0d exp v=1 d=%0d",
                     a_out_valid, a_out_data, blk_val(1, 0));
        end
`ifdef FIR_P2S_DROP_CNT_EN
        checks++;
        if (a_drop_cnt !== 16'd1) begin
            errors++;
            $display("[TB] FAIL full_drop_cnt got=%0d exp=1", a_drop_cnt);
        end
`endif

        // A clear in the same cycle as a drop must lose to the drop.
        load_a(6);
        a_in_valid = 1'b1;
        a_clr_ovf  = 1'b1;
        tick();
        a_in_valid = 1'b0;
        a_clr_ovf  = 1'b0;
        checks++;
        if (a_overflow !== 1'b1) begin
            errors++;
            $display("[TB] FAIL clr_vs_drop_overflow got=%b exp=1", a_overflow);
        end
`ifdef FIR_P2S_DROP_CNT_EN
        checks++;
        if (a_drop_cnt !== 16'd2) begin
            errors++;
            $display("[TB] FAIL clr_vs_drop_cnt got=%0d exp=2", a_drop_cnt);
        end
`endif
        a_clr_ovf = 1'b1;
        tick();
        a_clr_ovf = 1'b0;
        checks++;
        if (a_overflow !== 1'b0) begin
            errors++;
            $display("[TB] FAIL clr_overflow got=%b exp=0", a_overflow);
        end
`ifdef FIR_P2S_DROP_CNT_EN
        checks++;
        if (a_drop_cnt !== 16'd0) begin
            errors++;
            $display("[TB] FAIL clr_drop_cnt got=%0d exp=0", a_drop_cnt);
        end
`endif

        // Step to idx=2 of block 1, then push while that element transfers.
        a_out_ready = 1'b1;
        tick();
        tick();
        checks++;
        if (a_out_data !== blk_val(1, 2) || a_out_last !== 1'b1) begin
            errors++;
            $display("[TB] FAIL pp_at_last got d=%0d l=%b exp d=%0d l=1",
                     a_out_data, a_out_last, blk_val(1, 2));
        end
        load_a(7);
        a_in_valid = 1'b1;
        tick();
        a_in_valid  = 1'b0;
        a_out_ready = 1'b0;
        checks++;
        if (a_overflow !== 1'b0) begin
            errors++;
            $display("[TB] FAIL pp_overflow got=%b exp=0", a_overflow);
        end
        // The FIFO must still be full, so one more block is dropped.
        load_a(8);
        a_in_valid = 1'b1;
        tick();
        a_in_valid = 1'b0;
        checks++;
        if (a_overflow !== 1'b1) begin
            errors++;
            $display("[TB] FAIL pp_still_full got=%b exp=1", a_overflow);
        end
        a_clr_ovf = 1'b1;
        tick();
        a_clr_ovf = 1'b0;

        a_out_ready = 1'b1;
        for (int b = 0; b < 4; b++) begin
            for (int e = 0; e < 3; e++) begin
                checks++;
                if (a_out_valid !== 1'b1 || a_out_data !== blk_val(order[b], e) ||
                    a_out_last !== (e == 2)) begin
                    errors++;
                    $display("[TB] FAIL drain_b%0d_e%0d got v=%b d=%0d l=%b exp v=1 d=%0d l=%b",
                             order[b], e, a_out_valid, a_out_data, a_out_last,
                             blk_val(order[b], e), (e == 2));
                end
                tick();
            end
        end
        checks++;
        if (a_out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL drain_empty got=%b exp=0", a_out_valid);
        end
    endtask

    task automatic test_reset_mid_block();
        a_out_ready = 1'b1;
        a_blk[0] = 32'd5;
        a_blk[1] = 32'd6;
        a_blk[2] = 32'd7;
        a_in_valid = 1'b1;
        tick();
        a_in_valid = 1'b0;
        tick();
        checks++;
        if (a_out_data !== 32'sd6) begin
            errors++;
            $display("[TB] FAIL rst_pre got=%0d exp=6", a_out_data);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (a_out_valid !== 1'b0 || a_out_last !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rst_mid got v=%b l=%b exp v=0 l=0", a_out_valid, a_out_last);
        end
        tick();
        rst_n = 1'b1;
        a_blk[0] = 32'd8;
        a_blk[1] = 32'd9;
        a_blk[2] = 32'd10;
        a_in_valid = 1'b1;
        tick();
        a_in_valid = 1'b0;
        for (int e = 0; e < 3; e++) begin
            checks++;
            if (a_out_valid !== 1'b1 || a_out_data !== (8 + e) || a_out_last !== (e == 2)) begin
                errors++;
                $display("[TB] FAIL rst_after_e%0d got v=%b d=%0d l=%b exp v=1 d=%0d l=%b",
                         e, a_out_valid, a_out_data, a_out_last, 8 + e, (e == 2));
            end
            tick();
        end
        checks++;
        if (a_out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rst_after_empty got=%b exp=0", a_out_valid);
        end
    endtask

    // L=2 at one block every two cycles. Each sample is checked against
    // its expected position in the stream.
    task automatic test_l2_stream();
        int rd;
        int blk_no;
        int exp_v;
        rd = 0;
        b_out_ready = 1'b1;
        for (int c = 0; c < 2010; c++) begin
            if ((c % 2 == 0) && (c < 2000)) begin
                b_blk[0]   = 32'(c * 7 + 1);
                b_blk[1]   = 32'(-(c * 7 + 2));
                b_in_valid = 1'b1;
            end else begin
                b_in_valid = 1'b0;
            end
            if (b_out_valid === 1'b1) begin
                blk_no = rd / 2;
                exp_v  = (rd % 2 == 0) ? (blk_no * 14 + 1) : -(blk_no * 14 + 2);
                checks++;
                if (b_out_data !== exp_v || b_out_last !== (rd % 2 == 1)) begin
                    errors++;
                    $display("[TB] FAIL l2_sample%0d got d=%0d l=%b exp d=%0d l=%b",
                             rd, b_out_data, b_out_last, exp_v, (rd % 2 == 1));
                end
                rd++;
            end
            tick();
        end
        b_in_valid = 1'b0;
        checks++;
        if (rd !== 2000) begin
            errors++;
            $display("[TB] FAIL l2_sample_count got=%0d exp=2000", rd);
        end
        checks++;
        if (b_overflow !== 1'b0) begin
            errors++;
            $display("[TB] FAIL l2_overflow got=%b exp=0", b_overflow);
        end
`ifdef FIR_P2S_DROP_CNT_EN
        checks++;
        if (b_drop_cnt !== 16'd0) begin
            errors++;
            $display("[TB] FAIL l2_drop_cnt got=%0d exp=0", b_drop_cnt);
        end
`endif
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_single_block();
        test_backpressure();
        test_full_fifo();
        test_reset_mid_block();
        test_l2_stream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
